// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and load results into a single
// registered register-file write port. Loads wait in a 2-entry in-order
// queue and drain only in cycles without an ALU write. A bypass network
// exposes the youngest pending value for two read addresses.
//
// Handshake: ALU results have no backpressure and are taken whenever
// aluValid is high. A load is transferred on a posedge where
// ldValid && ldReady. ldReady is a function of registered queue occupancy
// and reset only, so it never depends on ldValid in the same cycle.
module regfile_writeback #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            aluValid,
  input  logic [4:0]      aluReg,
  input  logic [SIZE-1:0] aluData,
  input  logic            ldValid,
  output logic            ldReady,
  input  logic [4:0]      ldReg,
  input  logic [SIZE-1:0] ldData,
  input  logic [4:0]      readReg1,
  input  logic [4:0]      readReg2,
  output logic            fwdHit1,
  output logic [SIZE-1:0] fwdData1,
  output logic            fwdHit2,
  output logic [SIZE-1:0] fwdData2,
  output logic            regWrite,
  output logic [4:0]      writeReg,
  output logic [SIZE-1:0] writeData,
  output logic [1:0]      pending
);

  // Queue storage: entry 0 is the head (oldest), entry 1 the tail.
  // An occupied tail always implies an occupied head.
  logic [1:0]      q_valid_q, q_valid_d;
  logic [1:0]      q_live_q,  q_live_d;
  logic [4:0]      q_reg_q  [2];
  logic [4:0]      q_reg_d  [2];
  logic [SIZE-1:0] q_data_q [2];
  logic [SIZE-1:0] q_data_d [2];

  // Registered write-port stage.
  logic            reg_write_q, reg_write_d;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [SIZE-1:0] write_data_q, write_data_d;

  logic alu_eff;
  logic ld_acc;
  logic ld_enq;
  logic do_pop;

  assign pending  = q_valid_q[1] ? 2'd2 : (q_valid_q[0] ? 2'd1 : 2'd0);
  assign ldReady  = !reset && !q_valid_q[1];

  assign alu_eff  = aluValid && (aluReg != 5'd0);
  assign ld_acc   = ldValid && ldReady;
  // Loads to r0 are accepted to free the producer but never stored.
  assign ld_enq   = ld_acc && (ldReg != 5'd0);
  // The ALU always owns the write slot; the queue drains only when it is idle.
  assign do_pop   = !alu_eff && q_valid_q[0];

  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;

  // Queue next state: kill older entries hit by the ALU, pop, then enqueue.
  always_comb begin
    q_valid_d = q_valid_q;
    q_live_d  = q_live_q;
    q_reg_d   = q_reg_q;
    q_data_d  = q_data_q;

    // The ALU write is younger than anything already queued, so older
    // entries for the same register must never reach the register file.
    for (int i = 0; i < 2; i++) begin
      if (alu_eff && q_valid_q[i] && (q_reg_q[i] == aluReg)) begin
        q_live_d[i] = 1'b0;
      end
    end

    if (do_pop) begin
      q_valid_d[0] = q_valid_q[1];
      q_live_d[0]  = q_live_d[1];
      q_reg_d[0]   = q_reg_q[1];
      q_data_d[0]  = q_data_q[1];
      q_valid_d[1] = 1'b0;
      q_live_d[1]  = 1'b0;
    end

    // A load arriving alongside an ALU write to the same register is the
    // younger of the two, so it goes in live and is not subject to the kill.
    if (ld_enq) begin
      if (!q_valid_d[0]) begin
        q_valid_d[0] = 1'b1;
        q_live_d[0]  = 1'b1;
        q_reg_d[0]   = ldReg;
        q_data_d[0]  = ldData;
      end else begin
        q_valid_d[1] = 1'b1;
        q_live_d[1]  = 1'b1;
        q_reg_d[1]   = ldReg;
        q_data_d[1]  = ldData;
      end
    end
  end

  // Write-port next state: ALU first, else queue head, else idle and hold.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_eff) begin
      reg_write_d  = 1'b1;
      write_reg_d  = aluReg;
      write_data_d = aluData;
    end else if (do_pop) begin
      // A killed head still pops, but produces no write and leaves the
      // address/data lines untouched.
      reg_write_d = q_live_q[0];
      if (q_live_q[0]) begin
        write_reg_d  = q_reg_q[0];
        write_data_d = q_data_q[0];
      end
    end
  end

  // State register with synchronous reset; reset drops all queued loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid_q    <= 2'b00;
      q_live_q     <= 2'b00;
      q_reg_q[0]   <= 5'd0;
      q_reg_q[1]   <= 5'd0;
      q_data_q[0]  <= '0;
      q_data_q[1]  <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
    end else begin
      q_valid_q    <= q_valid_d;
      q_live_q     <= q_live_d;
      q_reg_q      <= q_reg_d;
      q_data_q     <= q_data_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Youngest-first bypass lookup over registered state: tail, head, output.
  function automatic logic [SIZE:0] fwd_lookup(input logic [4:0] addr);
    logic [SIZE:0] res;
    res = '0;
    if (addr != 5'd0) begin
      if (q_valid_q[1] && q_live_q[1] && (q_reg_q[1] == addr)) begin
        res = {1'b1, q_data_q[1]};
      end else if (q_valid_q[0] && q_live_q[0] && (q_reg_q[0] == addr)) begin
        res = {1'b1, q_data_q[0]};
      end else if (reg_write_q && (write_reg_q == addr)) begin
        res = {1'b1, write_data_q};
      end
    end
    return res;
  endfunction

  // Bypass for read port 1.
  always_comb begin
    {fwdHit1, fwdData1} = fwd_lookup(readReg1);
  end

  // Bypass for read port 2.
  always_comb begin
    {fwdHit2, fwdData2} = fwd_lookup(readReg2);
  end

endmodule
